// File: rtl/pcs_lock_pkg.sv
// Shared encodings for the PCS FEC / no-FEC lock negotiation.
package pcs_lock_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_HOLD_FEC   = 3'd1;
  localparam logic [2:0] ST_TRY_FEC    = 3'd2;
  localparam logic [2:0] ST_FEC_UP     = 3'd3;
  localparam logic [2:0] ST_HOLD_NOFEC = 3'd4;
  localparam logic [2:0] ST_TRY_NOFEC  = 3'd5;
  localparam logic [2:0] ST_NOFEC_UP   = 3'd6;

  localparam logic [1:0] MODE_AUTO  = 2'b00;
  localparam logic [1:0] MODE_FEC   = 2'b01;
  localparam logic [1:0] MODE_NOFEC = 2'b10;

  localparam int ATT_W = 4;

  // The reserved encoding 11 behaves as auto.
  function automatic logic [1:0] eff_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_AUTO : m;
  endfunction

  function automatic logic fec_side(input logic [2:0] s);
    return (s == ST_HOLD_FEC) || (s == ST_TRY_FEC) ||
           (s == ST_FEC_UP);
  endfunction

  function automatic logic nofec_side(input logic [2:0] s);
    return (s == ST_HOLD_NOFEC) || (s == ST_TRY_NOFEC) ||
           (s == ST_NOFEC_UP);
  endfunction

endpackage

// File: rtl/pcs_lock_ctrl_timer.sv
// Block-count timer: counts enabled blocks, expires at limit-1.
module pcs_blk_timer #(
  parameter int CNT_W = 13
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             ena,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      cnt <= '0;
    end else if (ena) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = ena && (cnt == limit - 1'b1);

endmodule

// File: rtl/pcs_lock_ctrl.sv
// Lock-acquisition sequencer choosing FEC or raw block sync
// for the 64b/66b receive PCS.
module pcs_lock_ctrl
  import pcs_lock_pkg::*;
#(
  parameter int FEC_TO_BLKS   = 4096,
  parameter int NOFEC_TO_BLKS = 1024,
  parameter int HOLDOFF_BLKS  = 64,
  parameter int MAX_ATTEMPTS  = 15,
  parameter int CNT_W         = 13
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       GB_BLK_ENA,
  input  logic       FEC_LOCK,
  input  logic       BLOCK_LOCK,
  input  logic [1:0] CSR_MODE,
  input  logic       CSR_RESTART,
  output logic       MODE_NO_FEC,
  output logic       FEC_SRCH_RST,
  output logic       CSR_STAT_LINK_UP,
  output logic [2:0] CSR_STAT_STATE,
  output logic [3:0] CSR_STAT_ATTEMPTS,
  output logic       CSR_EXPT_LOCK_FAIL
);

  localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(HOLDOFF_BLKS);
  localparam logic [CNT_W-1:0] L_FEC   = CNT_W'(FEC_TO_BLKS);
  localparam logic [CNT_W-1:0] L_NOFEC = CNT_W'(NOFEC_TO_BLKS);
  localparam logic [ATT_W-1:0] ATT_MAX = ATT_W'(MAX_ATTEMPTS);

  logic [2:0]       state, state_nxt;
  logic [ATT_W-1:0] att, att_nxt;
  logic             fail, fail_nxt;
  logic [1:0]       mode;
  logic             bad_mode;
  logic             bump, won;
  logic [CNT_W-1:0] limit;
  logic             expire;

  assign mode = eff_mode(CSR_MODE);

  // A forced mode evicts the FSM from the other path's states.
  assign bad_mode =
    ((mode == MODE_FEC)   && nofec_side(state)) ||
    ((mode == MODE_NOFEC) && fec_side(state));

  always_comb begin
    limit = L_HOLD;
    if (state == ST_TRY_FEC) begin
      limit = L_FEC;
    end else if (state == ST_TRY_NOFEC) begin
      limit = L_NOFEC;
    end
  end

  pcs_blk_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (state_nxt != state),
    .ena    (GB_BLK_ENA),
    .limit  (limit),
    .expire (expire)
  );

  always_comb begin
    state_nxt = state;
    bump      = 1'b0;
    won       = 1'b0;
    if (CSR_RESTART || bad_mode) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = (mode == MODE_NOFEC) ?
                      ST_HOLD_NOFEC : ST_HOLD_FEC;
        end
        ST_HOLD_FEC: begin
          if (expire) state_nxt = ST_TRY_FEC;
        end
        ST_TRY_FEC: begin
          if (FEC_LOCK) begin
            state_nxt = ST_FEC_UP;
            won       = 1'b1;
          end else if (expire) begin
            bump      = (mode == MODE_FEC);
            state_nxt = (mode == MODE_FEC) ?
                        ST_HOLD_FEC : ST_HOLD_NOFEC;
          end
        end
        ST_FEC_UP: begin
          if (!FEC_LOCK) state_nxt = ST_HOLD_FEC;
        end
        ST_HOLD_NOFEC: begin
          if (expire) state_nxt = ST_TRY_NOFEC;
        end
        ST_TRY_NOFEC: begin
          if (BLOCK_LOCK) begin
            state_nxt = ST_NOFEC_UP;
            won       = 1'b1;
          end else if (expire) begin
            bump      = 1'b1;
            state_nxt = (mode == MODE_NOFEC) ?
                        ST_HOLD_NOFEC : ST_HOLD_FEC;
          end
        end
        ST_NOFEC_UP: begin
          if (!BLOCK_LOCK) state_nxt = ST_HOLD_NOFEC;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    att_nxt  = att;
    fail_nxt = fail;
    if (CSR_RESTART) begin
      att_nxt  = '0;
      fail_nxt = 1'b0;
    end else if (won) begin
      att_nxt = '0;
    end else if (bump && (att != ATT_MAX)) begin
      att_nxt = att + 1'b1;
      if (att_nxt == ATT_MAX) fail_nxt = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state            <= ST_IDLE;
      att              <= '0;
      fail             <= 1'b0;
      MODE_NO_FEC      <= 1'b0;
      CSR_STAT_LINK_UP <= 1'b0;
      FEC_SRCH_RST     <= 1'b0;
    end else begin
      state            <= state_nxt;
      att              <= att_nxt;
      fail             <= fail_nxt;
      MODE_NO_FEC      <= nofec_side(state_nxt);
      CSR_STAT_LINK_UP <= (state_nxt == ST_FEC_UP) ||
                          (state_nxt == ST_NOFEC_UP);
      FEC_SRCH_RST     <= (state_nxt == ST_HOLD_FEC) &&
                          (state != ST_HOLD_FEC);
    end
  end

  assign CSR_STAT_STATE     = state;
  assign CSR_STAT_ATTEMPTS  = att;
  assign CSR_EXPT_LOCK_FAIL = fail;

endmodule
